pc_call_counter: RTL and testbench

- Parametrised program counter with a built-in return-address stack.
- Successor to the 12-bit loadable counter.
- Adds configurable width, configurable stack depth, call/return, a wrap indication and error flags.
- Sits in the CPU fetch stage; drives the program-memory address. The decoder drives load/call/ret/enable.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_call_counter_if.sv | 33 +++
 rtl/pc_call_counter_ret_stack.sv | 68 ++++++
 rtl/pc_call_counter.sv | 96 +++++++++
 tb/tb_pc_call_counter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: default PC/stack geometry and the
// priority-resolved program-counter operation.
package cpu_pkg;

    localparam int PC_WIDTH  = 12;
    localparam int RET_DEPTH = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_RET,
        PC_CALL,
        PC_LOAD
    } pc_op_t;

    // Exactly one action per cycle; load beats call beats ret beats increment.
    function automatic pc_op_t resolve_op(input logic load, input logic call,
                                          input logic ret, input logic enable);
        pc_op_t op;
        op = PC_HOLD;
        if (load)        op = PC_LOAD;
        else if (call)   op = PC_CALL;
        else if (ret)    op = PC_RET;
        else if (enable) op = PC_INC;
        return op;
    endfunction

endpackage

// File: rtl/pc_call_counter_if.sv
// Decoder <-> program-counter bundle; master is the decoder, slave the counter.
interface pc_call_counter_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = RET_DEPTH
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             enable;
    logic             load;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             wrap;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output enable, load, call, ret, target,
        input  pc, depth, full, empty, wrap, ovf_err, unf_err
    );

    modport slave (
        input  enable, load, call, ret, target,
        output pc, depth, full, empty, wrap, ovf_err, unf_err
    );

endinterface

// File: rtl/pc_call_counter_ret_stack.sv
// Return-address LIFO; push wins over pop, and both are ignored when they
// would over- or under-run the stack.
module ret_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [DW-1:0]    ptr_reg;
    logic [DW-1:0]    ptr_next;
    logic [WIDTH-1:0] entry_reg [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (ptr_reg == DW'(DEPTH));
    assign empty   = (ptr_reg == '0);
    assign depth   = ptr_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !push && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr
            assign wr_en[gi] = push_ok && (ptr_reg == DW'(gi));
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (push_ok)
            ptr_next = ptr_reg + 1'b1;
        else if (pop_ok)
            ptr_next = ptr_reg - 1'b1;
    end

    // Top of stack is the entry just below the pointer; zero when empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ptr_reg == DW'(i + 1))
                top = entry_reg[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
            for (int i = 0; i < DEPTH; i++)
                entry_reg[i] <= '0;
        end else begin
            ptr_reg <= ptr_next;
            for (int i = 0; i < DEPTH; i++)
                if (wr_en[i])
                    entry_reg[i] <= data_in;
        end
    end

endmodule

// File: rtl/pc_call_counter.sv
// Fetch-stage program counter with return-address stack, wrap pulse and
// sticky overflow/underflow flags.
module pc_call_counter
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter int               DEPTH       = RET_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    pc_call_counter_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);

    pc_op_t           op;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] stack_top;
    logic [DW-1:0]    stk_depth;
    logic             stk_full;
    logic             stk_empty;
    logic             push;
    logic             pop;
    logic             wrap_reg, wrap_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    assign op       = resolve_op(bus.load, bus.call, bus.ret, bus.enable);
    assign pc_plus1 = pc_reg + 1'b1;
    assign push     = (op == PC_CALL);
    assign pop      = (op == PC_RET);

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (pc_plus1),
        .top     (stack_top),
        .depth   (stk_depth),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    // A refused call or ret leaves pc where it is and only raises its flag.
    always_comb begin
        pc_next   = pc_reg;
        wrap_next = 1'b0;
        ovf_next  = ovf_reg;
        unf_next  = unf_reg;
        case (op)
            PC_LOAD: pc_next = bus.target;
            PC_CALL: begin
                if (stk_full) ovf_next = 1'b1;
                else          pc_next  = bus.target;
            end
            PC_RET: begin
                if (stk_empty) unf_next = 1'b1;
                else           pc_next  = stack_top;
            end
            PC_INC: begin
                pc_next   = pc_plus1;
                wrap_next = (pc_reg == '1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg   <= RESET_VALUE;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            unf_reg  <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            wrap_reg <= wrap_next;
            ovf_reg  <= ovf_next;
            unf_reg  <= unf_next;
        end
    end

    assign bus.pc      = pc_reg;
    assign bus.depth   = stk_depth;
    assign bus.full    = stk_full;
    assign bus.empty   = stk_empty;
    assign bus.wrap    = wrap_reg;
    assign bus.ovf_err = ovf_reg;
    assign bus.unf_err = unf_reg;

endmodule

// File: tb/tb_pc_call_counter.sv
// Randomised + directed bench for pc_call_counter: a 12-bit/4-deep instance
// and an 8-bit/1-deep instance against an arithmetic reference model.
module tb_pc_call_counter;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_call_counter_if #(.WIDTH(12), .DEPTH(4)) ifa ();
    pc_call_counter_if #(.WIDTH(8),  .DEPTH(1)) ifb ();

    pc_call_counter #(.WIDTH(12), .DEPTH(4), .RESET_VALUE(12'h000)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pc_call_counter #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one entry per DUT (0 = 12-bit/4-deep, 1 = 8-bit/1-deep)
    int mod_v [2] = '{4096, 256};
    int dep_v [2] = '{4, 1};
    int m_pc  [2];
    int m_sp  [2];
    int m_stk [2][8];
    bit m_wrap[2];
    bit m_ovf [2];
    bit m_unf [2];

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d]   = 0;
            m_sp[d]   = 0;
            m_wrap[d] = 1'b0;
            m_ovf[d]  = 1'b0;
            m_unf[d]  = 1'b0;
        end
    endfunction

    function automatic pc_op_t pick_op(input bit ld, input bit cl,
                                       input bit rt, input bit en);
        if (ld) return PC_LOAD;
        if (cl) return PC_CALL;
        if (rt) return PC_RET;
        if (en) return PC_INC;
        return PC_HOLD;
    endfunction

    function automatic void model_step(input int d, input pc_op_t op, input int tgt);
        m_wrap[d] = 1'b0;
        case (op)
            PC_LOAD: m_pc[d] = tgt % mod_v[d];
            PC_CALL: begin
                if (m_sp[d] < dep_v[d]) begin
                    m_stk[d][m_sp[d]] = (m_pc[d] + 1) % mod_v[d];
                    m_sp[d]++;
                    m_pc[d] = tgt % mod_v[d];
                end else begin
                    m_ovf[d] = 1'b1;
                end
            end
            PC_RET: begin
                if (m_sp[d] > 0) begin
                    m_sp[d]--;
                    m_pc[d] = m_stk[d][m_sp[d]];
                end else begin
                    m_unf[d] = 1'b1;
                end
            end
            PC_INC: begin
                m_wrap[d] = (m_pc[d] == mod_v[d] - 1);
                m_pc[d]   = (m_pc[d] + 1) % mod_v[d];
            end
            default: ;
        endcase
    endfunction

    task automatic compare(input int d);
        logic [31:0] pc, dp;
        logic        fu, em, wr, ov, un;
        string       nm;
        if (d == 0) begin
            nm = "a";
            pc = 32'(ifa.pc);  dp = 32'(ifa.depth);
            fu = ifa.full;     em = ifa.empty;   wr = ifa.wrap;
            ov = ifa.ovf_err;  un = ifa.unf_err;
        end else begin
            nm = "b";
            pc = 32'(ifb.pc);  dp = 32'(ifb.depth);
            fu = ifb.full;     em = ifb.empty;   wr = ifb.wrap;
            ov = ifb.ovf_err;  un = ifb.unf_err;
        end
        check_value({nm, ".pc"},    pc,       32'(m_pc[d]));
        check_value({nm, ".depth"}, dp,       32'(m_sp[d]));
        check_value({nm, ".full"},  32'(fu),  32'(m_sp[d] == dep_v[d]));
        check_value({nm, ".empty"}, 32'(em),  32'(m_sp[d] == 0));
        check_value({nm, ".wrap"},  32'(wr),  32'(m_wrap[d]));
        check_value({nm, ".ovf"},   32'(ov),  32'(m_ovf[d]));
        check_value({nm, ".unf"},   32'(un),  32'(m_unf[d]));
    endtask

    task automatic drive_idle();
        ifa.enable = 0; ifa.load = 0; ifa.call = 0; ifa.ret = 0; ifa.target = '0;
        ifb.enable = 0; ifb.load = 0; ifb.call = 0; ifb.ret = 0; ifb.target = '0;
    endtask

    task automatic step(input int d, input bit ld, input bit cl, input bit rt,
                        input bit en, input int tgt);
        pc_op_t op;
        op = pick_op(ld, cl, rt, en);
        drive_idle();
        if (d == 0) begin
            ifa.load = ld; ifa.call = cl; ifa.ret = rt; ifa.enable = en;
            ifa.target = 12'(tgt);
        end else begin
            ifb.load = ld; ifb.call = cl; ifb.ret = rt; ifb.enable = en;
            ifb.target = 8'(tgt);
        end
        @(posedge clk);
        #1;
        model_step(d, op, tgt);
        model_step(1 - d, PC_HOLD, 0);
        $display("[%0t] dut%0d op=%s tgt=%0h -> pc=%0h depth=%0d", $time, d,
                 op.name(), tgt, m_pc[d], m_sp[d]);
        compare(d);
    endtask

    task automatic random_run(input int d, input int n);
        int tgt;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                tgt = mod_v[d] - 2 + int'($urandom_range(0, 1));
            else
                tgt = int'($urandom_range(0, mod_v[d] - 1));
            step(d, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, tgt);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        compare(0);
        compare(1);

        // Asynchronous reset mid-count, then count again
        repeat (5) step(0, 0, 0, 0, 1, 0);
        drive_idle();
        #3 reset = 1'b1;
        #1;
        model_reset();
        $display("[%0t] dut0 async reset asserted", $time);
        compare(0);
        @(posedge clk);
        #1 reset = 1'b0;
        compare(0);
        repeat (3) step(0, 0, 0, 0, 1, 0);

        // Wrap from all-ones
        step(0, 1, 0, 0, 0, 12'hFFE);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Nested calls and returns
        step(0, 1, 0, 0, 0, 12'h010);
        step(0, 0, 1, 0, 0, 12'h100);
        step(0, 0, 1, 0, 0, 12'h200);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Overflow, then sticky flag through returns
        step(0, 0, 1, 0, 0, 12'h111);
        step(0, 0, 1, 0, 0, 12'h222);
        step(0, 0, 1, 0, 0, 12'h333);
        step(0, 0, 1, 0, 0, 12'h444);
        step(0, 0, 1, 0, 0, 12'h3AB);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Underflow and priority
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 1, 12'h0AA);
        step(0, 0, 1, 1, 0, 12'h123);

        random_run(0, 300);

        // Narrow, single-entry instance
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        compare(1);
        step(1, 1, 0, 0, 0, 8'hFF);
        step(1, 0, 1, 0, 0, 8'h40);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 8'h10);
        step(1, 0, 1, 0, 0, 8'h20);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);

        random_run(1, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
